load_store_unit: RTL and testbench

- Sits between the EX/MEM pipeline stage and the word-wide data memory.
- Accepts one load/store request at a time and sequences memory strobes.
- Supports byte, halfword and word accesses, big-endian; subword stores use read-modify-write.
- Returns sign- or zero-extended load data, or an error for misaligned accesses.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_lane_align.sv | 51 +++++
 rtl/load_store_unit.sv | 111 +++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and request layout for the load/store unit.
// Combinational helpers only; no latency, no backpressure.
package lsu_pkg;

  localparam int LSU_ADDR_W = 11;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_e;

  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       is_unsigned;
  } lsu_req_t;

  // Size 11 is reserved and is reported the same way as a misaligned access.
  function automatic logic lsu_bad_access(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return |offset;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane extraction with sign/zero extension, and subword store merge.
// Purely combinational: zero latency, no backpressure.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [15:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] byte_word;
  logic [31:0] half_word;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Offset 0 is the most significant lane, so the shift is (3 - offset) lanes.
  assign byte_sh   = {~offset, 3'b000};
  assign half_sh   = {~offset[1], 4'b0000};
  assign byte_word = word >> byte_sh;
  assign half_word = word >> half_sh;
  assign lane_b    = byte_word[7:0];
  assign lane_h    = half_word[15:0];

  always_comb begin
    load_data = word;
    merged    = word;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
        merged    = (word & ~(32'h0000_00ff << byte_sh)) |
                    ({24'h0, store_data[7:0]} << byte_sh);
      end
      SZ_HALF: begin
        load_data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
        merged    = (word & ~(32'h0000_ffff << half_sh)) |
                    ({16'h0, store_data} << half_sh);
      end
      default: begin
        load_data = word;
        merged    = word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer: one request at a time, RMW for subword stores; LSU_RANGE_CHECK_EN rejects out-of-range addresses.
// Latency error 1 / word store 2 / load 3 / subword store 4; req_ready low until the response cycle has passed.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state;
  lsu_req_t          req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wr_word;
  logic [31:0]       result;
  logic              err_q;
  logic              req_err;
  logic              range_err;
  logic [31:0]       load_data;
  logic [31:0]       merged;

`ifdef LSU_RANGE_CHECK_EN
  assign range_err = |req_addr[31:ADDR_W];
`else
  logic hi_bits_unused;
  assign hi_bits_unused = ^req_addr[31:ADDR_W];
  assign range_err      = 1'b0;
`endif

  assign req_err = lsu_bad_access(req_size, req_addr[1:0]) | range_err;

  // wr_word carries the raw store data until CAP replaces it with the merged word.
  lsu_lane_align u_lane_align (
    .word        (mem_rdata),
    .size        (req_q.size),
    .offset      (addr_q[1:0]),
    .is_unsigned (req_q.is_unsigned),
    .store_data  (wr_word[15:0]),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      wr_word <= '0;
      result  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q   <= '{write: req_write, size: req_size, is_unsigned: req_unsigned};
            addr_q  <= req_addr[ADDR_W-1:0];
            wr_word <= req_wdata;
            result  <= '0;
            err_q   <= req_err;
            if (req_err)
              state <= ST_RESP;
            else if (req_write && req_size == SZ_WORD)
              state <= ST_WR;
            else
              state <= ST_RD;
          end
        end
        ST_RD:  state <= ST_CAP;
        ST_CAP: begin
          if (req_q.write) begin
            wr_word <= merged;
            state   <= ST_WR;
          end else begin
            result <= load_data;
            state  <= ST_RESP;
          end
        end
        ST_WR:   state <= ST_RESP;
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign mem_read   = (state == ST_RD);
  assign mem_write  = (state == ST_WR);
  assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = mem_write ? wr_word : '0;
  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = resp_valid ? result : '0;
  assign resp_error = resp_valid & err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a registered 1-cycle word memory model.
// Builds with or without LSU_RANGE_CHECK_EN.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [10:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_addr     (mem_addr),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [0:511];
  always @(posedge clock) begin
    if (mem_read)  mem_rdata <= mem[mem_addr[10:2]];
    if (mem_write) mem[mem_addr[10:2]] <= mem_wdata;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wdata;
    int          acc;
    int          rd_base;
    int          wr_base;
    int          both_base;
  } exp_t;

  exp_t sb[$];

  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] last_wdata = '0;

  always @(negedge clock) begin
    exp_t e;
    if (mem_read)  rd_cnt++;
    if (mem_write) begin
      wr_cnt++;
      last_wdata = mem_wdata;
    end
    if (mem_read && mem_write) both_cnt++;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check("spurious_resp", {31'b0, resp_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_rdata"}, resp_rdata, e.rdata);
        check({e.tag, "_error"}, {31'b0, resp_error}, {31'b0, e.err});
        check({e.tag, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
        check({e.tag, "_reads"}, 32'(rd_cnt - e.rd_base), 32'(e.nrd));
        check({e.tag, "_writes"}, 32'(wr_cnt - e.wr_base), 32'(e.nwr));
        check({e.tag, "_rw_overlap"}, 32'(both_cnt - e.both_base), 32'd0);
        if (e.nwr > 0) check({e.tag, "_wdata"}, last_wdata, e.wdata);
      end
    end
  end

  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat,
                        input int nrd, input int nwr, input logic [31:0] exp_wd);
    exp_t e;
    int   g = 0;
    while (!req_ready && g < 50) begin
      @(posedge clock); #1;
      g++;
    end
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    @(posedge clock); #1;
    req_valid = 1'b0;
    e.tag = tag;  e.rdata = exp_rd;  e.err = exp_err;  e.lat = lat;
    e.nrd = nrd;  e.nwr = nwr;  e.wdata = exp_wd;  e.acc = cyc;
    e.rd_base = rd_cnt;  e.wr_base = wr_cnt;  e.both_base = both_cnt;
    sb.push_back(e);
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(posedge clock); #1;
      g++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int g;
    reset = 1'b1;  req_valid = 1'b0;  req_write = 1'b0;  req_size = SZ_BYTE;
    req_unsigned = 1'b0;  req_addr = '0;  req_wdata = '0;
    #12;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;

    do_req("sw_10",  1, SZ_WORD, 0, 32'h010, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1, 32'hDEADBEEF);
    do_req("lw_10",  0, SZ_WORD, 0, 32'h010, 32'h0, 32'hDEADBEEF, 0, 3, 1, 0, 32'h0);
    do_req("sw_pat", 1, SZ_WORD, 0, 32'h010, 32'h80FF7F01, 32'h0, 0, 2, 0, 1, 32'h80FF7F01);
    do_req("lb_10",  0, SZ_BYTE, 0, 32'h010, 32'h0, 32'hFFFFFF80, 0, 3, 1, 0, 32'h0);
    do_req("lbu_11", 0, SZ_BYTE, 1, 32'h011, 32'h0, 32'h000000FF, 0, 3, 1, 0, 32'h0);
    do_req("lh_12",  0, SZ_HALF, 0, 32'h012, 32'h0, 32'h00007F01, 0, 3, 1, 0, 32'h0);
    do_req("lh_10",  0, SZ_HALF, 0, 32'h010, 32'h0, 32'hFFFF80FF, 0, 3, 1, 0, 32'h0);
    do_req("lhu_10", 0, SZ_HALF, 1, 32'h010, 32'h0, 32'h000080FF, 0, 3, 1, 0, 32'h0);
    do_req("lb_13",  0, SZ_BYTE, 0, 32'h013, 32'h0, 32'h00000001, 0, 3, 1, 0, 32'h0);

    do_req("sw_base", 1, SZ_WORD, 0, 32'h010, 32'h11223344, 32'h0, 0, 2, 0, 1, 32'h11223344);
    do_req("sb_11",   1, SZ_BYTE, 0, 32'h011, 32'hFFFFFFAA, 32'h0, 0, 4, 1, 1, 32'h11AA3344);
    do_req("lw_sb",   0, SZ_WORD, 0, 32'h010, 32'h0, 32'h11AA3344, 0, 3, 1, 0, 32'h0);
    do_req("sh_12",   1, SZ_HALF, 0, 32'h012, 32'h1234BEEF, 32'h0, 0, 4, 1, 1, 32'h11AABEEF);
    do_req("lw_sh",   0, SZ_WORD, 0, 32'h010, 32'h0, 32'h11AABEEF, 0, 3, 1, 0, 32'h0);

    do_req("lh_mis",  0, SZ_HALF, 0, 32'h013, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0);
    do_req("sw_mis",  1, SZ_WORD, 0, 32'h022, 32'h55555555, 32'h0, 1, 1, 0, 0, 32'h0);
    do_req("sz_rsv",  0, 2'b11,   0, 32'h000, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0);
    drain();

    // Abort a byte store while its write strobe is up; memory must keep the old word.
    do_req("sb_abort", 1, SZ_BYTE, 0, 32'h010, 32'h00000055, 32'h0, 0, 4, 1, 1, 32'h55AABEEF);
    g = 0;
    while (!mem_write && g < 20) begin
      @(posedge clock); #1;
      g++;
    end
    check("abort_reached_wr", {31'b0, mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_mem_write", {31'b0, mem_write}, 32'd0);
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    sb.delete();
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    do_req("lw_abort", 0, SZ_WORD, 0, 32'h010, 32'h0, 32'h11AABEEF, 0, 3, 1, 0, 32'h0);

    do_req("sw_04", 1, SZ_WORD, 0, 32'h004, 32'hCAFEF00D, 32'h0, 0, 2, 0, 1, 32'hCAFEF00D);
`ifdef LSU_RANGE_CHECK_EN
    do_req("lw_804", 0, SZ_WORD, 0, 32'h804, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0);
`else
    do_req("lw_804", 0, SZ_WORD, 0, 32'h804, 32'h0, 32'hCAFEF00D, 0, 3, 1, 0, 32'h0);
`endif
    drain();
    check("rw_overlap_total", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
